reg_file_arbiter: RTL and testbench



---
 rtl/reg_arb_pkg.sv | 18 +
 rtl/reg_arb_age_counter.sv | 30 +++
 rtl/reg_file_arbiter.sv | 139 +++++++++++++
 tb/tb_reg_file_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types and constants for the register-file arbiter.
// Holds the FSM state enum, the access-owner enum and the address width.
package reg_arb_pkg;

   localparam int REG_ADDR_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      RESP
   } state_t;

   typedef enum logic {
      OWN_CPU,
      OWN_DBG
   } owner_t;

endpackage

// File: rtl/reg_arb_age_counter.sv
// reg_arb_age_counter: saturating count of contested CPU grants.
// Ports: Clk, Reset (sync, active-high), inc, clr, limit_hit (count == LIMIT).
module reg_arb_age_counter #(
   parameter int LIMIT = 4
) (
   input  logic Clk,
   input  logic Reset,
   input  logic inc,
   input  logic clr,
   output logic limit_hit
);

   localparam int CW = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(LIMIT);

   logic [CW-1:0] count_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (inc && (count_q != LIM)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign limit_hit = (count_q == LIM);

endmodule

// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter: shares the register file write port and SR1 read path
// between the CPU (fixed priority) and the debug loader, one access per 3 cycles.
// Ports: Clk, Reset (sync, active-high); cpu_*/dbg_* req/we/addr/wdata in,
// ack/rdata out; rf_ld/rf_dr/rf_sr/rf_bus to the file, rf_sr_data from it.
// Define REG_ARB_AGING_EN to add debug anti-starvation after AGE_LIMIT grants.
module reg_file_arbiter
   import reg_arb_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int AGE_LIMIT = 4
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [REG_ADDR_W-1:0] cpu_addr,
   input  logic [WIDTH-1:0]      cpu_wdata,
   output logic                  cpu_ack,
   output logic [WIDTH-1:0]      cpu_rdata,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   input  logic [WIDTH-1:0]      dbg_wdata,
   output logic                  dbg_ack,
   output logic [WIDTH-1:0]      dbg_rdata,
   output logic                  rf_ld,
   output logic [REG_ADDR_W-1:0] rf_dr,
   output logic [REG_ADDR_W-1:0] rf_sr,
   output logic [WIDTH-1:0]      rf_bus,
   input  logic [WIDTH-1:0]      rf_sr_data
);

   if (AGE_LIMIT < 1) begin : g_bad_limit
      $error("AGE_LIMIT must be at least 1");
   end

   state_t                state_q, state_d;
   owner_t                owner_q;
   logic                  we_q;
   logic [REG_ADDR_W-1:0] addr_q;
   logic [WIDTH-1:0]      wdata_q;
   logic [WIDTH-1:0]      cpu_rdata_q;
   logic [WIDTH-1:0]      dbg_rdata_q;

   logic idle;
   logic grant;
   logic resp;
   logic any_req;
   logic dbg_win;
   logic limit_hit;

   assign idle    = (state_q == IDLE);
   assign grant   = (state_q == GRANT);
   assign resp    = (state_q == RESP);
   assign any_req = cpu_req | dbg_req;

   // Debug wins when uncontested, or when it has waited out the age limit.
   assign dbg_win = dbg_req & (~cpu_req | limit_hit);

`ifdef REG_ARB_AGING_EN
   logic age_inc;
   logic age_clr;

   assign age_inc = idle & cpu_req & dbg_req & ~dbg_win;
   assign age_clr = idle & (~dbg_req | dbg_win);

   reg_arb_age_counter #(
      .LIMIT (AGE_LIMIT)
   ) u_age (
      .Clk       (Clk),
      .Reset     (Reset),
      .inc       (age_inc),
      .clr       (age_clr),
      .limit_hit (limit_hit)
   );
`else
   assign limit_hit = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_CPU;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (idle && any_req) begin
            owner_q <= dbg_win ? OWN_DBG : OWN_CPU;
            we_q    <= dbg_win ? dbg_we : cpu_we;
            addr_q  <= dbg_win ? dbg_addr : cpu_addr;
            wdata_q <= dbg_win ? dbg_wdata : cpu_wdata;
         end
         if (grant && !we_q) begin
            if (owner_q == OWN_DBG) begin
               dbg_rdata_q <= rf_sr_data;
            end else begin
               cpu_rdata_q <= rf_sr_data;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rf_ld   = 1'b0;
      rf_dr   = '0;
      rf_sr   = '0;
      rf_bus  = '0;
      cpu_ack = 1'b0;
      dbg_ack = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_req) state_d = GRANT;
         end
         GRANT: begin
            // Reset in the grant cycle must stop the write from landing.
            rf_ld   = we_q & ~Reset;
            rf_dr   = addr_q;
            rf_sr   = addr_q;
            rf_bus  = wdata_q;
            state_d = RESP;
         end
         RESP: begin
            cpu_ack = (owner_q == OWN_CPU);
            dbg_ack = (owner_q == OWN_DBG);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// tb_reg_file_arbiter: scoreboard bench for reg_file_arbiter with a
// behavioural 8x16 register file on the rf_* pins.
module tb_reg_file_arbiter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [2:0]  cpu_addr, dbg_addr;
   logic [15:0] cpu_wdata, dbg_wdata;
   logic        cpu_ack, dbg_ack;
   logic [15:0] cpu_rdata, dbg_rdata;
   logic        rf_ld;
   logic [2:0]  rf_dr, rf_sr;
   logic [15:0] rf_bus, rf_sr_data;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit          dbg;
      bit          rd;
      logic [15:0] data;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [15:0] rf [8];
   logic [15:0] sh [8];

   reg_file_arbiter #(.WIDTH(16), .AGE_LIMIT(4)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_ack    (cpu_ack),
      .cpu_rdata  (cpu_rdata),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_ack    (dbg_ack),
      .dbg_rdata  (dbg_rdata),
      .rf_ld      (rf_ld),
      .rf_dr      (rf_dr),
      .rf_sr      (rf_sr),
      .rf_bus     (rf_bus),
      .rf_sr_data (rf_sr_data)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (rf_ld) rf[rf_dr] <= rf_bus;
   end

   assign rf_sr_data = rf[rf_sr];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input bit d, input bit r, input logic [15:0] v);
      exp_t x;
      x.dbg  = d;
      x.rd   = r;
      x.data = v;
      sb.push_back(x);
   endtask

   always @(negedge Clk) begin
      if (cpu_ack && dbg_ack) begin
         check("dual_ack", 1, 0);
      end else if (cpu_ack || dbg_ack) begin
         if (sb.size() == 0) begin
            check("unexp_ack", {31'd0, dbg_ack}, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("ack_owner", {31'd0, dbg_ack}, {31'd0, e.dbg});
            if (e.rd)
               check("rdata", dbg_ack ? dbg_rdata : cpu_rdata, e.data);
         end
      end
   end

   // Called at a negedge; returns negedges from request to own ack.
   task automatic access(input bit d, input bit w, input logic [2:0] a,
                         input logic [15:0] v, output int lat);
      lat = -1;
      if (d) begin
         dbg_req = 1; dbg_we = w; dbg_addr = a; dbg_wdata = v;
      end else begin
         cpu_req = 1; cpu_we = w; cpu_addr = a; cpu_wdata = v;
      end
      for (int k = 1; k <= 30; k++) begin
         @(negedge Clk);
         if (d ? dbg_ack : cpu_ack) begin
            lat = k;
            break;
         end
      end
      if (d) dbg_req = 0;
      else   cpu_req = 0;
      if (lat < 0) check("timeout", 0, 1);
   endtask

   task automatic wr(input bit d, input logic [2:0] a, input logic [15:0] v,
                     input string tag);
      int lat;
      push(d, 0, 16'h0);
      sh[a] = v;
      access(d, 1, a, v, lat);
      check(tag, lat, 2);
      @(negedge Clk);
   endtask

   task automatic rd(input bit d, input logic [2:0] a, input string tag);
      int lat;
      push(d, 1, sh[a]);
      access(d, 0, a, 16'h0, lat);
      check(tag, lat, 2);
      @(negedge Clk);
   endtask

   initial begin
      int lc, ld, n, first_dbg, dcnt, ccnt, t1, t2;
      logic [15:0] keep;

      for (int i = 0; i < 8; i++) begin
         rf[i] = 16'h0;
         sh[i] = 16'h0;
      end
      Reset = 1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
      repeat (3) @(negedge Clk);
      check("rst_ld", rf_ld, 0);
      check("rst_dr", rf_dr, 0);
      check("rst_bus", rf_bus, 0);
      check("rst_acks", {cpu_ack, dbg_ack}, 0);
      check("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
      Reset = 0;
      @(negedge Clk);

      // Reset in the grant cycle drops the write.
      wr(0, 3, 16'h5555, "r3_pre_lat");
      rd(0, 3, "r3_rd_lat");
      cpu_req = 1; cpu_we = 1; cpu_addr = 3; cpu_wdata = 16'hBEEF;
      @(negedge Clk);
      check("mid_grant_ld", rf_ld, 1);
      Reset = 1;
      cpu_req = 0;
      @(negedge Clk);
      check("mid_ld", rf_ld, 0);
      check("mid_dr_sr", {rf_dr, rf_sr}, 0);
      check("mid_bus", rf_bus, 0);
      check("mid_acks", {cpu_ack, dbg_ack}, 0);
      check("mid_rdata", {cpu_rdata, dbg_rdata}, 0);
      Reset = 0;
      repeat (4) @(negedge Clk);
      rd(0, 3, "r3_keep_lat");

      // Single CPU write then read.
      wr(0, 5, 16'h1234, "r5_wr_lat");
      rd(0, 5, "r5_rd_lat");

      // Debug-only read leaves CPU rdata alone.
      wr(1, 0, 16'h00AA, "r0_wr_lat");
      keep = cpu_rdata;
      rd(1, 0, "r0_rd_lat");
      check("cpu_rdata_keep", cpu_rdata, keep);

      // Simultaneous writes to r1.
      push(0, 0, 16'h0);
      push(1, 0, 16'h0);
      fork
         access(0, 1, 1, 16'h0001, lc);
         access(1, 1, 1, 16'h0002, ld);
      join
      sh[1] = 16'h0002;
      check("sim_cpu_lat", lc, 2);
      check("sim_dbg_lat", ld, 5);
      @(negedge Clk);
      rd(0, 1, "r1_rd_lat");

      // Contested stream with both requests held high.
      cpu_req = 1; cpu_we = 0; cpu_addr = 1;
      dbg_req = 1; dbg_we = 0; dbg_addr = 1;
`ifdef REG_ARB_AGING_EN
      for (int i = 0; i < 4; i++) push(0, 1, sh[1]);
      push(1, 1, sh[1]);
      push(0, 1, sh[1]);
      n = 0;
      first_dbg = -1;
      for (int k = 0; k < 60 && n < 6; k++) begin
         @(negedge Clk);
         if (cpu_ack || dbg_ack) begin
            n++;
            if (dbg_ack) begin
               dbg_req = 0;
               if (first_dbg < 0) first_dbg = n;
            end
         end
      end
      cpu_req = 0;
      dbg_req = 0;
      check("age_acks", n, 6);
      check("age_dbg_pos", first_dbg, 5);
`else
      for (int i = 0; i < 17; i++) push(0, 1, sh[1]);
      ccnt = 0;
      dcnt = 0;
      for (int k = 0; k < 60 && ccnt < 17; k++) begin
         @(negedge Clk);
         if (cpu_ack) ccnt++;
         if (dbg_ack) dcnt++;
      end
      cpu_req = 0;
      dbg_req = 0;
      check("starve_cpu", ccnt, 17);
      check("starve_dbg", dcnt, 0);
`endif
      @(negedge Clk);
      @(negedge Clk);

      // Request held one cycle past ack is a second access.
      push(0, 1, sh[5]);
      push(0, 1, sh[5]);
      cpu_req = 1; cpu_we = 0; cpu_addr = 5;
      t1 = -1;
      t2 = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge Clk);
         if (cpu_ack) begin
            if (t1 < 0) t1 = k;
            else begin
               t2 = k;
               break;
            end
         end
         if (t1 >= 0 && k == t1 + 2) cpu_req = 0;
      end
      cpu_req = 0;
      check("proto_first", t1, 2);
      check("proto_gap", t2 - t1, 3);
      repeat (3) @(negedge Clk);
      check("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
